// File: rtl/qdiv_arbiter.sv
// qdiv_arbiter: round-robin front end that shares one sequential qdiv divider
// between NREQ requesters. Captures the winner's operands, pulses div_start,
// waits out the divider's fixed latency and returns the tagged quotient.
// Optional feature macro: QDIV_ARB_DIVZERO_EN (zero-divisor bypass with
// saturated result and rsp_divzero flag).
module qdiv_arbiter #(
  parameter int Q           = 15,
  parameter int N           = 32,
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int DIV_LATENCY = N + Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic [N-1:0]      div_dividend,
  output logic [N-1:0]      div_divisor,
  output logic              div_start,
  input  logic [N-1:0]      div_quotient,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_quotient,
`ifdef QDIV_ARB_DIVZERO_EN
  output logic              rsp_divzero,
`endif
  output logic              busy
);

  localparam int CW = $clog2(DIV_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IDW-1:0]          r_rr_ptr;
  logic                    r_rr_vld;   // 0 until the first grant: search then starts at 0
  logic [IDW-1:0]          r_id;
  logic [IDW-1:0]          r_rsp_id;
  logic                    r_div_start;
  logic                    r_rsp_valid;
  logic                    r_busy;
  logic [N-1:0]            r_div_a;
  logic [N-1:0]            r_div_b;
  logic [N-1:0]            r_rsp_q;
`ifdef QDIV_ARB_DIVZERO_EN
  logic                    r_rsp_dz;
`endif

  logic [NREQ-1:0][N-1:0]  w_dvd;
  logic [NREQ-1:0][N-1:0]  w_dvs;
  int                      w_base;
  logic                    w_found;
  logic [IDW-1:0]          w_g;
  logic [IDW-1:0]          w_idx;
  logic [N-1:0]            w_a;
  logic [N-1:0]            w_b;

  assign w_dvd = req_dividend;
  assign w_dvs = req_divisor;

  // Round-robin search: first valid requester upward (with wrap) from rr_ptr+1
  always_comb begin
    w_base  = 0;
    w_found = 1'b0;
    w_g     = '0;
    w_idx   = '0;
    if (r_rr_vld) w_base = (int'(r_rr_ptr) + 1) % NREQ;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((w_base + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_g     = w_idx;
      end
    end
    w_a = w_dvd[w_g];
    w_b = w_dvs[w_g];
  end

  // Ready is only offered from IDLE, and never while reset is asserted
  always_comb begin
    req_ready = '0;
    if (!rst && r_state == S_IDLE && w_found) req_ready[w_g] = 1'b1;
  end

  // Control FSM: capture -> launch divider -> count latency -> hold response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_rr_vld    <= 1'b0;
      r_id        <= '0;
      r_rsp_id    <= '0;
      r_div_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_rsp_q     <= '0;
`ifdef QDIV_ARB_DIVZERO_EN
      r_rsp_dz    <= 1'b0;
`endif
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_div_a  <= w_a;
            r_div_b  <= w_b;
            r_id     <= w_g;
            r_rr_ptr <= w_g;
            r_rr_vld <= 1'b1;
            r_busy   <= 1'b1;
`ifdef QDIV_ARB_DIVZERO_EN
            if (w_b[N-2:0] == '0) begin
              // Zero magnitude divisor: answer directly with a saturated quotient
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= w_g;
              r_rsp_q     <= {w_a[N-1] ^ w_b[N-1], {(N-1){1'b1}}};
              r_rsp_dz    <= 1'b1;
            end else
`endif
            begin
              r_state     <= S_LAUNCH;
              r_div_start <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_cnt   <= CW'(DIV_LATENCY - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_q     <= div_quotient;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
`ifdef QDIV_ARB_DIVZERO_EN
            r_rsp_dz    <= 1'b0;
`endif
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div_dividend = r_div_a;
  assign div_divisor  = r_div_b;
  assign div_start    = r_div_start;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_quotient = r_rsp_q;
  assign busy         = r_busy;
`ifdef QDIV_ARB_DIVZERO_EN
  assign rsp_divzero  = r_rsp_dz;
`endif

endmodule

// File: tb/tb_qdiv_arbiter.sv
// tb_qdiv_arbiter: directed bench with a transaction-level model of the
// arbiter (grant rotation, fixed response latency, expected quotient) and a
// behavioural qdiv stub with fixed latency.
module tb_qdiv_arbiter;
  localparam int Q = 15, N = 32, NREQ = 4, IDW = 2, LAT = 47;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][N-1:0] dvd;
  logic [NREQ-1:0][N-1:0] dvs;
  logic [N-1:0]           div_dividend, div_divisor, div_quotient, rsp_quotient;
  logic                   div_start, rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]         rsp_id;
`ifdef QDIV_ARB_DIVZERO_EN
  logic                   rsp_divzero;
`endif

  always #5 clk = ~clk;

  qdiv_arbiter #(.Q(Q), .N(N), .NREQ(NREQ), .IDW(IDW), .DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(dvd), .req_divisor(dvs),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
    .div_quotient(div_quotient), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
`ifdef QDIV_ARB_DIVZERO_EN
    .rsp_divzero(rsp_divzero),
`endif
    .busy(busy));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sign-magnitude Q-format division (reference for the qdiv stub and the model)
  function automatic logic [31:0] qref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num, mag;
    num = {33'b0, a[30:0]} << Q;
    if (b[30:0] == 31'd0) mag = 64'h7FFF_FFFF;
    else                  mag = num / {33'b0, b[30:0]};
    return {a[31] ^ b[31], mag[30:0]};
  endfunction

  function automatic logic [31:0] exp_q(input logic [31:0] a, input logic [31:0] b);
`ifdef QDIV_ARB_DIVZERO_EN
    if (b[30:0] == 31'd0) return {a[31] ^ b[31], 31'h7FFF_FFFF};
`endif
    return qref(a, b);
  endfunction

  // qdiv stub: result valid LAT cycles after div_start, garbage before
  int s_cnt;
  bit s_act;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt <= 0;
      s_act <= 1'b0;
    end else if (div_start) begin
      s_cnt <= 1;
      s_act <= 1'b1;
    end else if (s_act && s_cnt < 1000) begin
      s_cnt <= s_cnt + 1;
    end
  end
  assign div_quotient = (s_act && s_cnt >= LAT) ? qref(div_dividend, div_divisor) : 32'hDEAD_BEEF;

  // Transaction model state
  bit          m_busy = 1'b0;
  int          m_cyc  = 0;
  int          m_last = -1;
  int          m_g;
  int          m_id;
  logic [31:0] m_a, m_b, m_q;
  bit          m_dz;
  bit          m_seen;
  bit          m_expv;
  int          grants[$];
  int          n_start = 0;
  int          r_lat;
  logic [31:0] r_q;
  int          r_id;
  bit          r_dz;

  // Compare process: one check set per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", {req_ready, div_start, rsp_valid, busy, rsp_id}, 64'd0);
      chk("rst_div_a", div_dividend, 64'd0);
      chk("rst_div_b", div_divisor, 64'd0);
      chk("rst_rsp_q", rsp_quotient, 64'd0);
`ifdef QDIV_ARB_DIVZERO_EN
      chk("rst_dz", rsp_divzero, 64'd0);
`endif
      m_busy = 1'b0;
      m_last = -1;
    end else if (!m_busy) begin
      m_g = -1;
      for (int k = 0; k < NREQ; k++)
        if (m_g < 0 && req_valid[IDW'((m_last + 1 + k) % NREQ)]) m_g = (m_last + 1 + k) % NREQ;
      chk("idle_busy", busy, 64'd0);
      chk("idle_start", div_start, 64'd0);
      chk("idle_rsp", rsp_valid, 64'd0);
      if (m_g < 0) begin
        chk("idle_noready", req_ready, 64'd0);
      end else begin
        chk("grant", req_ready, 64'd1 << m_g);
        m_busy = 1'b1;
        m_cyc  = 0;
        m_id   = m_g;
        m_a    = dvd[IDW'(m_g)];
        m_b    = dvs[IDW'(m_g)];
`ifdef QDIV_ARB_DIVZERO_EN
        m_dz   = (m_b[30:0] == 31'd0);
`else
        m_dz   = 1'b0;
`endif
        m_q    = exp_q(m_a, m_b);
        m_last = m_g;
        m_seen = 1'b0;
        grants.push_back(m_g);
      end
    end else begin
      m_cyc++;
      if (div_start) n_start++;
      chk("busy_noready", req_ready, 64'd0);
      chk("busy", busy, 64'd1);
      chk("div_start", div_start, (m_cyc == 1 && !m_dz) ? 64'd1 : 64'd0);
      chk("div_a_hold", div_dividend, m_a);
      chk("div_b_hold", div_divisor, m_b);
      m_expv = (m_cyc >= (m_dz ? 1 : LAT + 2));
      chk("rsp_valid", rsp_valid, m_expv);
      if (m_expv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_q", rsp_quotient, m_q);
`ifdef QDIV_ARB_DIVZERO_EN
        chk("rsp_dz", rsp_divzero, m_dz);
`endif
        if (!m_seen) begin
          m_seen = 1'b1;
          r_lat  = m_cyc;
          r_q    = rsp_quotient;
          r_id   = rsp_id;
`ifdef QDIV_ARB_DIVZERO_EN
          r_dz   = rsp_divzero;
`else
          r_dz   = 1'b0;
`endif
        end
        if (rsp_ready) m_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b);
    int c;
    dvd[IDW'(idx)] = a;
    dvs[IDW'(idx)] = b;
    req_valid[IDW'(idx)] = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!req_ready[IDW'(idx)] && c < 300);
    if (!req_ready[IDW'(idx)]) chk("issue_timeout", c, 0);
    tick();
    req_valid[IDW'(idx)] = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (m_busy && c < 400) begin
      tick();
      c++;
    end
    if (m_busy) chk("idle_timeout", c, 0);
  endtask

  int ns0;
  int c;
  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; dvd = '0; dvs = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: single request, fixed latency and value
    ns0 = n_start;
    issue(0, 32'h0020_1000, 32'h0001_0000);
    wait_idle();
    chk("t1_lat", r_lat, 49);
    chk("t1_q", r_q, 32'h0010_0800);
    chk("t1_id", r_id, 0);
    chk("t1_starts", n_start - ns0, 1);

    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();

    // 2: all four held -> strict rotation
    grants.delete();
    for (int i = 0; i < NREQ; i++) begin
      dvd[IDW'(i)] = 32'h0000_8000 * (i + 1);
      dvs[IDW'(i)] = 32'h0000_4000;
    end
    req_valid = 4'hF;
    c = 0;
    while (grants.size() < 5 && c < 400) begin tick(); c++; end
    req_valid = '0;
    wait_idle();
    chk("t2_ngrant", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("t2_order", grants[i], order[i]);

    // 3: response backpressure, pending req1 granted right after accept
    rsp_ready = 1'b0;
    issue(2, 32'h0001_8000, 32'h0000_C000);
    dvd[1] = 32'h8002_8000; dvs[1] = 32'h0001_0000; req_valid[1] = 1'b1;
    c = 0;
    while (!rsp_valid && c < 100) begin tick(); c++; end
    repeat (10) tick();
    chk("t3_q", rsp_quotient, 32'h0001_0000);
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t3_next_grant", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;

    // 4: reset in the middle of WAIT, then a fresh operation
    c = 0;
    while (m_cyc < 20 && c < 100) begin tick(); c++; end
    rst = 1'b1;
    #1;
    chk("t4_rst_now", {busy, rsp_valid, div_start, req_ready}, 64'd0);
    tick(); rst = 1'b0; tick();
    ns0 = n_start;
    issue(2, 32'h8003_0000, 32'h0000_2000);
    wait_idle();
    chk("t4_id", r_id, 2);
    chk("t4_q", r_q, 32'h800C_0000);
    chk("t4_starts", n_start - ns0, 1);

    // 6: requester operands change while the divider runs
    issue(3, 32'h0020_1000, 32'h0001_0000);
    dvd[3] = 32'h1234_5678; dvs[3] = 32'h0000_0001;
    wait_idle();
    chk("t6_q", r_q, 32'h0010_0800);
    chk("t6_lat", r_lat, 49);

`ifdef QDIV_ARB_DIVZERO_EN
    // 5: zero divisor bypass
    ns0 = n_start;
    issue(3, 32'h8000_8000, 32'h8000_0000);
    wait_idle();
    chk("t5_lat", r_lat, 1);
    chk("t5_q", r_q, 32'h7FFF_FFFF);
    chk("t5_dz", r_dz, 1);
    chk("t5_id", r_id, 3);
    chk("t5_starts", n_start - ns0, 0);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
